demux_1x2_stream: RTL

- Splits one valid/ready input stream onto two output channels, steering each beat by a select bit.
- Performs the inverse of the 2:1 select path used elsewhere in the RTL2GDS datapath.
- Each channel has its own small FIFO, so one stalled consumer does not block beats bound for the other channel once those beats are accepted.
- Sits between a shared producer and two independent consumers.

---
 rtl/demux_1x2_stream_if.sv | 31 +++
 rtl/demux_1x2_stream.sv | 95 +++++++++
 2 files changed

// File: rtl/demux_1x2_stream_if.sv
// Bus for demux_1x2_stream: one producer stream in, two consumer channels out.
// master = environment side (producer + consumers), slave = the demux itself.
interface demux_1x2_stream_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_sel;
   logic          out0_valid;
   logic          out0_ready;
   logic [W-1:0]  out0_data;
   logic          out1_valid;
   logic          out1_ready;
   logic [W-1:0]  out1_data;
   logic [LW-1:0] out0_level;
   logic [LW-1:0] out1_level;

   modport master (
      output in_valid, in_data, in_sel, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_level, out1_level
   );

   modport slave (
      input  in_valid, in_data, in_sel, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_level, out1_level
   );
endinterface

// File: rtl/demux_1x2_stream.sv
// 1:2 stream demux with a small FIFO per output channel.
// Define DEMUX_AUTO_ALT_EN to ignore in_sel and alternate ch0/ch1 per accepted beat.
module demux_1x2_stream #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   demux_1x2_stream_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  mem_q    [2][DEPTH];
   logic [AW-1:0] wr_ptr_q [2];
   logic [AW-1:0] rd_ptr_q [2];
   logic [LW-1:0] level_q  [2];

   logic [1:0] full;
   logic [1:0] empty;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] out_ready;
   logic       dst;
   logic       accept;

`ifdef DEMUX_AUTO_ALT_EN
   logic alt_q;
   logic unused_sel;

   assign unused_sel = bus.in_sel;
   assign dst        = alt_q;

   // Toggle only moves on accepted beats, so a stall keeps the pending channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alt_q <= 1'b0;
      end else if (accept) begin
         alt_q <= ~alt_q;
      end
   end
`else
   assign dst = bus.in_sel;
`endif

   assign out_ready    = {bus.out1_ready, bus.out0_ready};
   // Depends only on the destination and the level registers, never on out*_ready.
   assign bus.in_ready = ~full[dst];
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         full[k]  = (level_q[k] == LW'(DEPTH));
         empty[k] = (level_q[k] == '0);
         pop[k]   = ~empty[k] & out_ready[k];
         push[k]  = accept & (int'(dst) == k);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            level_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
               wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
            end
            if (pop[k]) begin
               rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
            end
            level_q[k] <= level_q[k] + LW'(push[k]) - LW'(pop[k]);
         end
      end
   end

   // Storage needs no reset; the level registers decide what is valid.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_q[k][wr_ptr_q[k]] <= bus.in_data;
         end
      end
   end

   assign bus.out0_valid = ~empty[0];
   assign bus.out1_valid = ~empty[1];
   assign bus.out0_data  = empty[0] ? '0 : mem_q[0][rd_ptr_q[0]];
   assign bus.out1_data  = empty[1] ? '0 : mem_q[1][rd_ptr_q[1]];
   assign bus.out0_level = level_q[0];
   assign bus.out1_level = level_q[1];
endmodule
